quad_encoder_gen: RTL
=====================

Name: quad_encoder_gen

Overview:
Quadrature encoder stimulus generator. It drives A/B/0 signals with the same edge convention that the board-side quad_encoder decoder counts, so the decoder, its debouncers and the counter_ab/counter_at_res/counter_err registers can be exercised from a test fixture or a master-side board. Commands arrive over a valid/ready handshake. Each command gives a direction, a step count and an edge spacing. The block keeps its own 4x position and emits an index pulse once per revolution.

Parameters:
COUNT_W, 16, width of cmd_steps and of the position counter
PERIOD_W, 16, width of cmd_period (clocks between quadrature edges)
ZERO_PERIOD, 4000, counts (4x edges) per revolution; must be a multiple of 4 and >= 4

Ports:
clock  in  1  system clock (clk100 domain)
n_reset  in  1  asynchronous, active-low reset
cmd_valid  in  1  command request
cmd_ready  out  1  block can accept a command
cmd_dir  in  1  1 = forward (A leads B), 0 = reverse
cmd_steps  in  COUNT_W  number of quadrature edges to emit
cmd_period  in  PERIOD_W  clocks per edge; 0 is treated as 1
abort  in  1  stop the running command at the next edge boundary
a_out  out  1  encoder A
b_out  out  1  encoder B
n_out  out  1  index (zero) pulse
position  out  COUNT_W  current position, range 0..ZERO_PERIOD-1
busy  out  1  command in progress
done  out  1  one-cycle pulse when a command completes or is aborted

Behaviour:
- Reset (n_reset=0, asynchronous):
  - a_out=0, b_out=0, n_out=0, position=0, busy=0, done=0.
  - cmd_ready=1 once reset is released.
  - All state is cleared and any running command is dropped without a done pulse.
- Phase sequence, (A,B):
  - Forward: 00 -> 10 -> 11 -> 01 -> 00.
  - Reverse: the same sequence run backwards.
  - Phase is derived from position[1:0]: 0=00, 1=10, 2=11, 3=01.
- Position arithmetic:
  - Forward: position+1; ZERO_PERIOD-1 wraps to 0.
  - Reverse: position-1; 0 wraps to ZERO_PERIOD-1.
- States: IDLE, RUN, FINISH.
- IDLE:
  - cmd_ready=1, busy=0.
  - On cmd_valid & cmd_ready: latch dir, steps and period (with 0 replaced by 1).
  - Load the period counter with period-1 and the remaining-step counter with steps.
  - If steps==0, go to FINISH; otherwise go to RUN.
  - cmd_ready drops in the cycle after acceptance.
- RUN:
  - busy=1.
  - The period counter decrements each clock.
  - When it reaches 0: apply one edge (update position, a_out, b_out and n_out in that same register update), decrement the remaining-step counter, and reload the period counter.
  - First edge: exactly `period` clocks after the acceptance cycle. Following edges: every `period` clocks.
  - After the edge that takes the remaining-step counter to 0, go to FINISH.
- Abort:
  - Sampled only at edge time.
  - If abort=1 in the cycle an edge would be applied, that edge is suppressed and the block goes to FINISH.
  - Abort in IDLE has no effect.
- FINISH:
  - done=1 for exactly one cycle.
  - busy=0 and cmd_ready=1 in the following cycle (IDLE).
- Commands arriving while busy are not accepted (cmd_ready=0); the requester holds cmd_valid.
- n_out:
  - Registered. Set to 1 when an edge lands on position==0.
  - Cleared by the next edge in either direction.
  - Not asserted at reset, even though position is 0.
- Direction reversal between commands continues from the current phase; no extra edge is inserted.
- Outputs are glitch-free: a_out and b_out come straight from flops, and at most one of them changes per edge.

Test Plan:
1. Reset, then command dir=1, steps=8, period=10 -> A/B sequence 10,11,01,00,10,11,01,00; edges at 10,20,...,80 clocks after acceptance; position 8; done pulse 1 cycle after the 8th edge.
2. Forward to position 3996 (ZERO_PERIOD=4000), then steps=4 -> position wraps 3999 -> 0; n_out=1 from the 4th edge until the next edge; then dir=0, steps=1 -> position 3999 and n_out=0.
3. dir=0 from reset, steps=2 -> position 3999 then 3998; (A,B) = 01 then 11; n_out stays 0.
4. cmd_steps=0 -> no A/B activity; done asserts in the cycle after acceptance; cmd_ready high again the following cycle.
5. steps=100, period=5, abort held high after the 3rd edge -> exactly 3 edges, position 3, done asserted at the 4th edge time and no 4th edge.
6. Run steps=50 and pull n_reset low mid-command -> all outputs immediately 0, no done pulse; cmd_valid held during busy -> not accepted until cmd_ready=1.

Source files
------------

// File: rtl/quad_encoder_gen_if.sv
// Command channel of the quadrature encoder stimulus generator.
// The requester holds cmd_valid and the payload stable until cmd_ready is seen.
interface quad_encoder_gen_if #(
   parameter int COUNT_W  = 16,
   parameter int PERIOD_W = 16
);
   logic                cmd_valid;
   logic                cmd_ready;
   logic                cmd_dir;
   logic [COUNT_W-1:0]  cmd_steps;
   logic [PERIOD_W-1:0] cmd_period;

   modport master (
      output cmd_valid, cmd_dir, cmd_steps, cmd_period,
      input  cmd_ready
   );

   modport slave (
      input  cmd_valid, cmd_dir, cmd_steps, cmd_period,
      output cmd_ready
   );
endinterface

// File: rtl/quad_encoder_gen.sv
// Quadrature encoder stimulus generator: emits A/B/index edges for commanded
// step counts at a fixed edge spacing, tracking its own 4x position.
module quad_encoder_gen #(
   parameter int COUNT_W     = 16,
   parameter int PERIOD_W    = 16,
   parameter int ZERO_PERIOD = 4000
) (
   input  logic                clock,
   input  logic                n_reset,
   quad_encoder_gen_if.slave   cmd,
   input  logic                abort,
   output logic                a_out,
   output logic                b_out,
   output logic                n_out,
   output logic [COUNT_W-1:0]  position,
   output logic                busy,
   output logic                done
);

   typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

   localparam logic [COUNT_W-1:0]  POS_MAX  = COUNT_W'(ZERO_PERIOD - 1);
   localparam logic [COUNT_W-1:0]  STEP_ONE = COUNT_W'(1);
   localparam logic [PERIOD_W-1:0] PER_ONE  = PERIOD_W'(1);

   state_t              state_q, state_d;
   logic                dir_q;
   logic [PERIOD_W-1:0] period_q;
   logic [PERIOD_W-1:0] period_cnt;
   logic [COUNT_W-1:0]  steps_left;
   logic [COUNT_W-1:0]  pos_next;
   logic [PERIOD_W-1:0] period_eff;
   logic                accept;
   logic                edge_fire;

   // Gray-coded phase taken from the low position bits; only one of A/B flips per step.
   function automatic logic [1:0] phase_of(input logic [1:0] p);
      case (p)
         2'd0:    phase_of = 2'b00;
         2'd1:    phase_of = 2'b10;
         2'd2:    phase_of = 2'b11;
         default: phase_of = 2'b01;
      endcase
   endfunction

   assign period_eff    = (cmd.cmd_period == '0) ? PER_ONE : cmd.cmd_period;
   assign cmd.cmd_ready = (state_q == IDLE);
   assign busy          = (state_q == RUN);
   assign done          = (state_q == FINISH);

   always_comb begin
      pos_next = position;
      if (dir_q) begin
         pos_next = (position == POS_MAX) ? '0 : position + STEP_ONE;
      end else begin
         pos_next = (position == '0) ? POS_MAX : position - STEP_ONE;
      end
   end

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      state_d   = state_q;
      accept    = 1'b0;
      edge_fire = 1'b0;
      case (state_q)
         IDLE: begin
            if (cmd.cmd_valid) begin
               accept  = 1'b1;
               state_d = (cmd.cmd_steps == '0) ? FINISH : RUN;
            end
         end
         RUN: begin
            if (period_cnt == '0) begin
               if (abort) begin
                  state_d = FINISH;
               end else begin
                  edge_fire = 1'b1;
                  if (steps_left == STEP_ONE) state_d = FINISH;
               end
            end
         end
         FINISH:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clock or negedge n_reset) begin
      if (!n_reset) state_q <= IDLE;
      else          state_q <= state_d;
   end

   always_ff @(posedge clock or negedge n_reset) begin
      if (!n_reset) begin
         dir_q      <= 1'b0;
         period_q   <= PER_ONE;
         period_cnt <= '0;
         steps_left <= '0;
         position   <= '0;
         a_out      <= 1'b0;
         b_out      <= 1'b0;
         n_out      <= 1'b0;
      end else if (accept) begin
         dir_q      <= cmd.cmd_dir;
         period_q   <= period_eff;
         period_cnt <= period_eff - PER_ONE;
         steps_left <= cmd.cmd_steps;
      end else if (edge_fire) begin
         position       <= pos_next;
         {a_out, b_out} <= phase_of(pos_next[1:0]);
         n_out          <= (pos_next == '0);
         steps_left     <= steps_left - STEP_ONE;
         period_cnt     <= period_q - PER_ONE;
      end else if (state_q == RUN && period_cnt != '0) begin
         period_cnt <= period_cnt - PER_ONE;
      end
   end

endmodule
